bcd_addsub_serial: RTL
======================

Name: bcd_addsub_serial

Overview:
- Parametrised, digit-serial packed-BCD add/subtract unit for the calculator datapath.
- Successor to the fixed 2-digit combinational BCD adder. Generalises to DIGITS digits and processes one digit per clock, LSD first.
- Adds a start/busy/done handshake, signed subtraction results (sign plus magnitude via a recomplement pass) and invalid-digit detection.
- Sits between operand registers and the display/result register.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1). Operand width W = 4*DIGITS (localparam).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  2  00 ADD, 10 SUB (op1-op2), 01/11 reserved
- op1  input  W  packed BCD operand A, digit 0 = bits [3:0]
- op2  input  W  packed BCD operand B
- busy  output  1  high while the operation is in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- result  output  W  packed BCD sum, or magnitude of the difference
- carry_out  output  1  ADD overflow out of the MSD; always 0 for SUB
- negative  output  1  SUB result < 0 (result holds |op1-op2|)
- error  output  1  invalid operand digit or reserved opcode

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset.
- On reset: state=IDLE, busy=0, done=0, result=0, carry_out=0, negative=0, error=0, digit counter=0. This applies mid-operation too; the current operation is abandoned and no done is issued.
- FSM states: IDLE, CALC, RECOMP, DONE.
- IDLE -> start=1 on edge k:
  - Latch op1, op2 and opcode into shift registers.
  - Clear carry_out, negative and error.
  - Set the carry register to 1 for SUB, 0 for ADD.
- Validity check at start: if any nibble of op1/op2 exceeds 9, or the opcode is reserved, set error=1, result=0, and go directly to DONE. Otherwise go to CALC.
- CALC, one digit per cycle for DIGITS cycles:
  - Operand: a = A digit, b = B digit for ADD, or (9 - B digit) for SUB.
  - Raw sum: s = a + b + c (5-bit).
  - Correction: if s > 9, digit = s + 6 (low nibble) and c' = 1; else digit = s and c' = 0.
  - Each digit is shifted into result from the MSD end; operands shift right by 4.
- Leaving CALC (after digit DIGITS-1):
  - ADD: carry_out = final c', then go to DONE.
  - SUB with final c'=1: result >= 0, negative=0, go to DONE.
  - SUB with final c'=0: negative=1, go to RECOMP.
- RECOMP, DIGITS cycles: replace result with its ten's complement, digit-serial, using the same digit adder with a = 9 - r_digit, b = 0, carry-in 1 at digit 0. Then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Output hold: result, carry_out, negative and error hold until the next accepted start or reset.
- busy is 1 in CALC and RECOMP only.
- Latency, counted in cycles after the start edge:
  - Valid op: done is high in cycle DIGITS+1.
  - Negative SUB: done is high in cycle 2*DIGITS+1.
  - Error: done is high in cycle 1.
- Boundary conditions:
  - start is ignored outside IDLE; there is no queueing.
  - start in the DONE cycle is ignored.
  - Inputs may change freely after the start edge; they are latched.
  - ADD all-9s + all-9s gives result 99..98, carry_out=1.
  - SUB equal operands gives result 0, negative=0 (no negative zero).
  - DIGITS=1 must work; the digit counter must still be at least 1 bit wide.

Decomposition:
- Shared package bcd_pkg:
  - opcode enum (OP_ADD=2'b00, OP_SUB=2'b10)
  - FSM state enum
  - constants BCD_MAX=4'd9, BCD_ADJ=4'd6
- One sub-module, bcd_digit_adder: combinational inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout (decimal-adjusted).
  - Instantiated once and time-shared between CALC and RECOMP via input muxing.

Test Plan (DIGITS=4):
- ADD 1234 + 5678, start pulse -> busy for 4 cycles; done in cycle 5; result=6912, carry_out=0, negative=0, error=0.
- ADD 9999 + 0001 -> result=0000, carry_out=1, done in cycle 5.
- SUB 5000 - 1234 -> result=3766, negative=0, carry_out=0, done in cycle 5.
- SUB 1234 - 5000 -> RECOMP entered; result=3766, negative=1, done in cycle 9.
- Invalid/reserved inputs:
  - op1=0x12A4 ADD -> error=1, result=0, done in cycle 1.
  - opcode=01 -> error=1.
- Control-path corner cases:
  - start asserted again during busy -> ignored; first result intact.
  - reset asserted at CALC cycle 2 -> all outputs 0, no done.
  - A new start after reset completes normally.
  - SUB 0042-0042 -> result=0000, negative=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD add/subtract unit.
package bcd_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b10
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit decimal adder: a + b + cin with +6 correction; combinational, zero latency.
// Pure function of its inputs, no flow control.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = (raw > {1'b0, BCD_MAX});
    // Adding 6 modulo 16 skips the six non-decimal codes.
    sum  = cout ? (raw[3:0] + BCD_ADJ) : raw[3:0];
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD add/sub (LSD first), SUB as sign + magnitude. Done after DIGITS+1
// cycles (2*DIGITS+1 for negative SUB, 1 on error); start only sampled in IDLE, never queued.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            opcode,
  input  logic [4*DIGITS-1:0]   op1,
  input  logic [4*DIGITS-1:0]   op2,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  error
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_e         state, next_state;
  logic [W-1:0]   a_sh, b_sh;
  logic           op_sub;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           start_bad;

  logic [3:0]     add_a, add_b, add_sum;
  logic           add_cin, add_cout;
  logic [W-1:0]   result_shift;

  always_comb begin
    start_bad = (opcode != OP_ADD) && (opcode != OP_SUB);
    for (int i = 0; i < DIGITS; i++) begin
      if ((op1[4*i +: 4] > BCD_MAX) || (op2[4*i +: 4] > BCD_MAX)) start_bad = 1'b1;
    end
  end

  // The single digit adder is shared: CALC feeds operand digits, RECOMP feeds the
  // nine's complement of the result digit with a +1 injected through the carry.
  always_comb begin
    add_a   = a_sh[3:0];
    add_b   = op_sub ? (BCD_MAX - b_sh[3:0]) : b_sh[3:0];
    add_cin = carry;
    if (state == RECOMP) begin
      add_a = BCD_MAX - result[3:0];
      add_b = 4'd0;
    end
  end

  bcd_digit_adder u_digit_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // New digit enters at the MSD end so after DIGITS shifts digit 0 sits at [3:0].
  assign result_shift = W'({add_sum, result} >> 4);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = start_bad ? DONE : CALC;
      CALC:    if (cnt == LAST) next_state = (op_sub && !add_cout) ? RECOMP : DONE;
      RECOMP:  if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == RECOMP);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      op_sub    <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh      <= op1;
            b_sh      <= op2;
            op_sub    <= (opcode == OP_SUB);
            carry     <= (opcode == OP_SUB);
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
            error     <= start_bad;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          result <= result_shift;
          carry  <= add_cout;
          if (cnt == LAST) begin
            cnt <= '0;
            if (!op_sub) begin
              carry_out <= add_cout;
            end else if (!add_cout) begin
              // No end-around carry: the difference is negative and held in ten's complement.
              negative <= 1'b1;
              carry    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RECOMP: begin
          result <= result_shift;
          carry  <= add_cout;
          cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
